// File: rtl/life_sequencer.sv
// Generation scheduler for the Game of Life board engines: launches INIT or
// UPDATE->COPY on a vsync rising edge, with run/step/speed control and a watchdog.
module life_sequencer #(
  parameter int CLOCK_FREQ  = 24000000,
  parameter int GEN_W       = 16,
  parameter int WDOG_CYCLES = 32768
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             randomize,
  input  logic [1:0]       speed,
  input  logic             vsync,
  input  logic             init_done,
  input  logic             update_done,
  input  logic             copy_done,
  output logic             init_start,
  output logic             update_start,
  output logic             copy_start,
  output logic             busy,
  output logic [1:0]       state,
  output logic [GEN_W-1:0] generation,
  output logic             fault
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] INIT   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] COPY   = 2'd3;

  localparam int TW = $clog2(CLOCK_FREQ + 1);
  localparam int WW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  localparam logic [TW-1:0] IVAL_0    = TW'(CLOCK_FREQ / 10);
  localparam logic [TW-1:0] IVAL_1    = TW'(CLOCK_FREQ / 5);
  localparam logic [TW-1:0] IVAL_2    = TW'(CLOCK_FREQ / 2);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [TW-1:0]    timer, timer_nxt, interval;
  logic [WW-1:0]    wdog, wdog_nxt;
  logic             vsync_q, step_q, vsync_rise, step_rise;
  logic             step_pending, step_pending_nxt;
  logic             boot_pending;
  logic [1:0]       state_nxt;
  logic             init_s, update_s, copy_s, launch;
  logic [GEN_W-1:0] gen_nxt;
  logic             fault_nxt;

  always_comb begin
    case (speed)
      2'd0:    interval = IVAL_0;
      2'd1:    interval = IVAL_1;
      2'd2:    interval = IVAL_2;
      default: interval = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    init_s    = 1'b0;
    update_s  = 1'b0;
    copy_s    = 1'b0;
    launch    = 1'b0;
    gen_nxt   = generation;
    fault_nxt = fault;
    wdog_nxt  = '0;
    case (state)
      IDLE: begin
        if (boot_pending) begin
          launch    = 1'b1;
          init_s    = 1'b1;
          state_nxt = INIT;
        end else if (vsync_rise && ((run && (timer >= interval)) ||
                                    (!run && step_pending))) begin
          launch = 1'b1;
          if (randomize) begin
            init_s    = 1'b1;
            state_nxt = INIT;
          end else begin
            update_s  = 1'b1;
            state_nxt = UPDATE;
          end
        end
      end
      INIT: begin
        if (init_done) begin
          state_nxt = IDLE;
          gen_nxt   = '0;
        end else if (wdog == WDOG_LAST) begin
          state_nxt = IDLE;
          fault_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      UPDATE: begin
        if (update_done) begin
          state_nxt = COPY;
          copy_s    = 1'b1;
        end else if (wdog == WDOG_LAST) begin
          state_nxt = IDLE;
          fault_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      default: begin
        if (copy_done) begin
          state_nxt = IDLE;
          gen_nxt   = generation + 1'b1;
        end else if (wdog == WDOG_LAST) begin
          state_nxt = IDLE;
          fault_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
    endcase
  end

  // Timer only advances while idle and running; it is frozen during busy phases.
  always_comb begin
    timer_nxt = timer;
    if (launch)
      timer_nxt = '0;
    else if (state == IDLE && run && timer < interval)
      timer_nxt = timer + 1'b1;
  end

  // A new step edge outranks the clear from serving a request in the same cycle.
  always_comb begin
    step_pending_nxt = step_pending;
    if (run)
      step_pending_nxt = 1'b0;
    else if (step_rise)
      step_pending_nxt = 1'b1;
    else if (launch)
      step_pending_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      init_start   <= 1'b0;
      update_start <= 1'b0;
      copy_start   <= 1'b0;
      timer        <= '0;
      wdog         <= '0;
      generation   <= '0;
      fault        <= 1'b0;
      step_pending <= 1'b0;
      boot_pending <= 1'b1;
      vsync_q      <= 1'b0;
      step_q       <= 1'b0;
      vsync_rise   <= 1'b0;
      step_rise    <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      init_start   <= init_s;
      update_start <= update_s;
      copy_start   <= copy_s;
      timer        <= timer_nxt;
      wdog         <= wdog_nxt;
      generation   <= gen_nxt;
      fault        <= fault_nxt;
      step_pending <= step_pending_nxt;
      boot_pending <= 1'b0;
      vsync_q      <= vsync;
      step_q       <= step;
      vsync_rise   <= vsync & ~vsync_q;
      step_rise    <= step & ~step_q;
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer: boot, free run, pause/step, randomize,
// interval timer, watchdog expiry and mid-phase reset.
module tb_life_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step, randomize, vsync;
  logic [1:0]  speed;
  logic        init_done, update_done, copy_done;
  logic        init_start, update_start, copy_start, busy, fault;
  logic [1:0]  state;
  logic [15:0] generation;

  int checks = 0;
  int errors = 0;
  int n_init = 0;
  int n_upd  = 0;
  int n_copy = 0;

  always #5 clk = ~clk;

  life_sequencer #(
    .CLOCK_FREQ (100),
    .GEN_W      (16),
    .WDOG_CYCLES(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .randomize   (randomize),
    .speed       (speed),
    .vsync       (vsync),
    .init_done   (init_done),
    .update_done (update_done),
    .copy_done   (copy_done),
    .init_start  (init_start),
    .update_start(update_start),
    .copy_start  (copy_start),
    .busy        (busy),
    .state       (state),
    .generation  (generation),
    .fault       (fault)
  );

  always @(negedge clk) begin
    if (init_start)   n_init++;
    if (update_start) n_upd++;
    if (copy_start)   n_copy++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One vsync-launched UPDATE+COPY generation; engines answer after 10 cycles.
  task automatic frame_update(input int exp_gen);
    int u0, c0;
    u0 = n_upd;
    c0 = n_copy;
    vsync = 1'b1;
    tick();
    chk("no_start_at_rise_seen", update_start, 0);
    tick();
    chk("update_start", update_start, 1);
    chk("state_update", state, 2);
    chk("busy_update", busy, 1);
    tick();
    chk("update_start_one_cycle", update_start, 0);
    repeat (2) tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("mismatched_done_ignored", state, 2);
    repeat (4) tick();
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    chk("copy_start", copy_start, 1);
    chk("state_copy", state, 3);
    repeat (9) tick();
    copy_done = 1'b1;
    tick();
    copy_done = 1'b0;
    chk("state_idle_after_copy", state, 0);
    chk("generation", generation, exp_gen);
    chk("busy_idle", busy, 0);
    vsync = 1'b0;
    tick();
    chk("one_update_per_frame", n_upd, u0 + 1);
    chk("one_copy_per_frame", n_copy, c0 + 1);
  endtask

  initial begin
    int u0, c0, s0;
    reset = 1'b1; run = 1'b0; step = 1'b0; randomize = 1'b0; speed = 2'd3;
    vsync = 1'b0; init_done = 1'b0; update_done = 1'b0; copy_done = 1'b0;

    // Boot
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_init_start", init_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_generation", generation, 0);
    reset = 1'b0;
    tick();
    chk("boot_init_start", init_start, 1);
    chk("boot_state", state, 1);
    tick();
    chk("boot_init_start_one_cycle", init_start, 0);
    repeat (3) tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("boot_idle", state, 0);
    chk("boot_generation", generation, 0);

    // Free run, every frame
    run = 1'b1;
    speed = 2'd3;
    for (int i = 1; i <= 4; i++) frame_update(i);
    chk("free_run_gen4", generation, 4);

    // Pause with three step edges before a single vsync rise
    run = 1'b0;
    repeat (3) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end
    chk("steps_no_launch_without_vsync", state, 0);
    frame_update(5);
    u0 = n_upd;
    repeat (3) begin
      vsync = 1'b1; repeat (4) tick();
      vsync = 1'b0; repeat (2) tick();
    end
    chk("paused_no_starts", n_upd, u0);
    chk("paused_idle", state, 0);

    // Randomize launch
    run = 1'b1;
    randomize = 1'b1;
    u0 = n_upd;
    vsync = 1'b1;
    tick(); tick();
    chk("rand_init_start", init_start, 1);
    chk("rand_state_init", state, 1);
    chk("rand_no_update_start", update_start, 0);
    repeat (4) tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("rand_idle", state, 0);
    chk("rand_gen_cleared", generation, 0);
    chk("rand_no_update_count", n_upd, u0);

    // Interval timer (speed 0 -> 10 cycles with CLOCK_FREQ=100)
    vsync = 1'b0; randomize = 1'b0; speed = 2'd0;
    tick();
    vsync = 1'b1;
    tick(); tick();
    chk("timer_not_expired_no_start", update_start, 0);
    tick();
    chk("timer_not_expired_idle", state, 0);
    vsync = 1'b0;
    repeat (12) tick();
    frame_update(1);

    // Watchdog expiry during UPDATE
    speed = 2'd3;
    vsync = 1'b1;
    tick(); tick();
    chk("wd_update_start", update_start, 1);
    repeat (63) tick();
    chk("wd_pre_expiry_state", state, 2);
    chk("wd_pre_expiry_fault", fault, 0);
    tick();
    chk("wd_expired_state", state, 0);
    chk("wd_expired_fault", fault, 1);
    chk("wd_expired_busy", busy, 0);
    c0 = n_copy;
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    tick();
    chk("wd_stray_done_state", state, 0);
    chk("wd_stray_done_no_copy", n_copy, c0);
    chk("wd_gen_unchanged", generation, 1);
    chk("wd_fault_sticky", fault, 1);
    vsync = 1'b0;
    tick();

    // Reset clears fault and reboots
    reset = 1'b1;
    tick();
    chk("rst2_fault", fault, 0);
    reset = 1'b0;
    tick();
    chk("rst2_boot_init_start", init_start, 1);
    repeat (2) tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;

    // Done arriving in the expiry cycle wins
    vsync = 1'b1;
    tick(); tick();
    chk("wd2_update_start", update_start, 1);
    repeat (63) tick();
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    chk("wd2_state_copy", state, 3);
    chk("wd2_copy_start", copy_start, 1);
    chk("wd2_fault", fault, 0);
    repeat (3) tick();
    copy_done = 1'b1;
    tick();
    copy_done = 1'b0;
    chk("wd2_generation", generation, 1);
    vsync = 1'b0;
    tick();

    // Reset in the middle of UPDATE
    vsync = 1'b1;
    tick(); tick();
    chk("mid_state_update", state, 2);
    repeat (3) tick();
    reset = 1'b1;
    s0 = n_init + n_upd + n_copy;
    repeat (3) begin
      tick();
      chk("mid_rst_state", state, 0);
      chk("mid_rst_starts", {29'd0, init_start, update_start, copy_start}, 0);
    end
    reset = 1'b0;
    vsync = 1'b0;
    chk("mid_rst_no_start_counts", n_init + n_upd + n_copy, s0);
    tick();
    chk("mid_rst_init_start", init_start, 1);
    chk("mid_rst_state_init", state, 1);
    chk("mid_rst_generation", generation, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
